dmem_responder: RTL and testbench

- Data-memory responder for the core's load/store path. It answers word-addressed read and write requests issued by the execute/memory side through a valid/ready request channel and a valid/ready response channel.
- Holds a synthesizable word array with a configurable number of wait states, so pipeline stall logic is exercised.
- Flags misaligned and out-of-range accesses with an error response instead of corrupting memory.

---
 rtl/dmem_responder.sv | 149 ++++++++++++++
 tb/tb_dmem_responder.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-addressed data memory with byte-enable stores, configurable wait states and
// error responses for misaligned, out-of-range and empty-mask accesses.
module dmem_responder #(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_STATES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [3:0]  req_be_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o
);

   localparam int          IW        = $clog2(DEPTH_WORDS);
   localparam logic [32:0] RANGE     = 33'(DEPTH_WORDS) << 2;
   localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state_reg;
   logic [3:0]    cnt_reg;
   logic          we_reg;
   logic [31:0]   addr_reg;
   logic [31:0]   wdata_reg;
   logic [3:0]    be_reg;
   logic          valid_reg;
   logic          err_reg;

   logic          accept;
   logic          rsp_hs;
   logic          do_access;
   logic          acc_we;
   logic [31:0]   acc_addr;
   logic [31:0]   acc_wdata;
   logic [3:0]    acc_be;
   logic [32:0]   acc_off;
   logic [IW-1:0] acc_idx;
   logic          acc_err;

   assign req_ready_o = (state_reg == IDLE) && !rst_i;
   assign accept      = req_valid_i && req_ready_o;
   assign rsp_hs      = (state_reg == RESP) && rsp_ready_i;
   assign rsp_valid_o = valid_reg;
   assign rsp_err_o   = err_reg;

   // With no wait states the access happens on the acceptance edge, straight from the inputs.
   always_comb begin
      if (WAIT_STATES == 0) begin
         acc_we    = req_we_i;
         acc_addr  = req_addr_i;
         acc_wdata = req_wdata_i;
         acc_be    = req_be_i;
         do_access = accept;
      end else begin
         acc_we    = we_reg;
         acc_addr  = addr_reg;
         acc_wdata = wdata_reg;
         acc_be    = be_reg;
         do_access = (state_reg == WAIT) && (cnt_reg == 4'd0) && !rst_i;
      end
   end

   // An address below the base underflows to a huge offset, so one compare covers both ends.
   assign acc_off = {1'b0, acc_addr} - {1'b0, BASE_ADDR};
   assign acc_idx = IW'(acc_off >> 2);
   assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_off >= RANGE) ||
                    (acc_we && (acc_be == 4'd0));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
         valid_reg <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  we_reg    <= req_we_i;
                  addr_reg  <= req_addr_i;
                  wdata_reg <= req_wdata_i;
                  be_reg    <= req_be_i;
                  if (WAIT_STATES == 0) begin
                     state_reg <= RESP;
                     valid_reg <= 1'b1;
                     err_reg   <= acc_err;
                  end else begin
                     state_reg <= WAIT;
                     cnt_reg   <= WAIT_LOAD;
                  end
               end
            end
            WAIT: begin
               if (cnt_reg == 4'd0) begin
                  state_reg <= RESP;
                  valid_reg <= 1'b1;
                  err_reg   <= acc_err;
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  state_reg <= IDLE;
                  valid_reg <= 1'b0;
                  err_reg   <= 1'b0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // One byte-wide RAM per lane keeps the byte-enable write a plain single-port store.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem [DEPTH_WORDS];
         logic [7:0] rd_reg;

         always_ff @(posedge clk_i) begin
            if (do_access && !acc_err && acc_we && acc_be[gi]) begin
               mem[acc_idx] <= acc_wdata[8*gi +: 8];
            end
         end

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               rd_reg <= 8'd0;
            end else if (do_access) begin
               rd_reg <= (acc_err || acc_we) ? 8'd0 : mem[acc_idx];
            end else if (rsp_hs) begin
               rd_reg <= 8'd0;
            end
         end

         assign rsp_rdata_o[8*gi +: 8] = rd_reg;
      end
   endgenerate

endmodule

// File: tb/tb_dmem_responder.sv
// Three responders (1, 3 and 0 wait states) driven by directed and random transactions,
// checked against a word-array reference model of the memory.
module tb_dmem_responder;

   localparam int N     = 3;
   localparam int DEPTH = 256;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0] rst, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
   logic [31:0]  req_addr  [N];
   logic [31:0]  req_wdata [N];
   logic [3:0]   req_be    [N];
   logic [31:0]  rsp_rdata [N];

   logic [31:0]  model_mem [N][DEPTH];
   int tests_run    = 0;
   int tests_failed = 0;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_dut
         dmem_responder #(
            .DEPTH_WORDS(DEPTH),
            .WAIT_STATES((gi == 1) ? 3 : ((gi == 2) ? 0 : 1)),
            .BASE_ADDR((gi == 2) ? 32'h0000_1000 : 32'h0000_0000)
         ) u_dut (
            .clk_i      (clk),
            .rst_i      (rst[gi]),
            .req_valid_i(req_valid[gi]),
            .req_ready_o(req_ready[gi]),
            .req_we_i   (req_we[gi]),
            .req_addr_i (req_addr[gi]),
            .req_wdata_i(req_wdata[gi]),
            .req_be_i   (req_be[gi]),
            .rsp_valid_o(rsp_valid[gi]),
            .rsp_ready_i(rsp_ready[gi]),
            .rsp_rdata_o(rsp_rdata[gi]),
            .rsp_err_o  (rsp_err[gi])
         );
      end
   endgenerate

   function automatic int ws_of(int d);
      return (d == 1) ? 3 : ((d == 2) ? 0 : 1);
   endfunction

   function automatic logic [31:0] base_of(int d);
      return (d == 2) ? 32'h0000_1000 : 32'h0000_0000;
   endfunction

   function automatic bit exp_err(int d, bit we, logic [31:0] addr, logic [3:0] be);
      longint a, b;
      a = {32'd0, addr};
      b = {32'd0, base_of(d)};
      return (addr[1:0] != 2'b00) || (a < b) || (a >= b + 4 * DEPTH) || (we && be == 4'd0);
   endfunction

   function automatic int widx(int d, logic [31:0] addr);
      longint a, b;
      a = {32'd0, addr};
      b = {32'd0, base_of(d)};
      return int'((a - b) / 4);
   endfunction

   task automatic model_access(input int d, input bit we, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [3:0] be,
                               output logic [31:0] rd, output logic err);
      err = exp_err(d, we, addr, be);
      rd  = 32'd0;
      if (!err) begin
         if (we) begin
            for (int k = 0; k < 4; k++) begin
               if (be[k]) model_mem[d][widx(d, addr)][8*k +: 8] = wd[8*k +: 8];
            end
         end else begin
            rd = model_mem[d][widx(d, addr)];
         end
      end
   endtask

   // Runs one transaction; lat counts cycles from the acceptance cycle (1 = next cycle).
   task automatic do_txn(input int d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be,
                         output logic [31:0] rd, output logic err, output int lat, output bit ok);
      int n;
      ok = 1'b1; rd = 32'd0; err = 1'b0; lat = 0;
      @(negedge clk);
      req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wd; req_be[d] = be;
      n = 0;
      while (!req_ready[d] && n < 50) begin @(negedge clk); n++; end
      if (!req_ready[d]) begin ok = 1'b0; req_valid[d] = 1'b0; return; end
      @(negedge clk);
      req_valid[d] = 1'b0; req_we[d] = 1'($urandom); req_addr[d] = $urandom;
      req_wdata[d] = $urandom; req_be[d] = 4'($urandom);
      lat = 1;
      while (!rsp_valid[d] && lat < 40) begin @(negedge clk); lat++; end
      if (!rsp_valid[d]) begin ok = 1'b0; return; end
      rd = rsp_rdata[d]; err = rsp_err[d];
      rsp_ready[d] = 1'b1;
      @(negedge clk);
      rsp_ready[d] = 1'b0;
      $display("[TB] dut%0d %s addr=%h wdata=%h be=%b -> rdata=%h err=%b lat=%0d",
               d, we ? "ST" : "LD", addr, wd, be, rd, err, lat);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = '1; req_valid = '0; rsp_ready = '0;
      @(negedge clk);
      @(negedge clk);
      for (int d = 0; d < N; d++) begin
         tests_run++;
         if (req_ready[d] !== 1'b0) begin
            tests_failed++;
            $display("FAIL ready_in_reset dut%0d: got %b want 0", d, req_ready[d]);
         end
      end
      rst = '0;
      @(negedge clk);
      for (int d = 0; d < N; d++) begin
         tests_run++;
         if ({rsp_valid[d], rsp_err[d], rsp_rdata[d], req_ready[d]} !== {1'b0, 1'b0, 32'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_state dut%0d: got valid=%b err=%b rdata=%h ready=%b want 0 0 0 1",
                     d, rsp_valid[d], rsp_err[d], rsp_rdata[d], req_ready[d]);
         end
      end
   endtask

   task automatic test_store_load();
      logic [31:0] rd; logic err; int lat; bit ok;
      do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, err, lat, ok);
      model_mem[0][4] = 32'hDEADBEEF;
      tests_run++;
      if (!ok || lat !== 2 || err !== 1'b0 || rd !== 32'd0) begin
         tests_failed++;
         $display("FAIL full_store: ok=%b lat=%0d err=%b rdata=%h want lat=2 err=0 rdata=0", ok, lat, err, rd);
      end
      do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat, ok);
      tests_run++;
      if (!ok || lat !== 2 || err !== 1'b0 || rd !== 32'hDEADBEEF) begin
         tests_failed++;
         $display("FAIL load_after_store: ok=%b lat=%0d err=%b rdata=%h want lat=2 err=0 rdata=deadbeef", ok, lat, err, rd);
      end
   endtask

   task automatic test_partial_store();
      logic [31:0] rd; logic err; int lat; bit ok;
      do_txn(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, rd, err, lat, ok);
      model_mem[0][4] = 32'hDE22BE44;
      tests_run++;
      if (!ok || err !== 1'b0 || rd !== 32'd0) begin
         tests_failed++;
         $display("FAIL partial_store: ok=%b err=%b rdata=%h want err=0 rdata=0", ok, err, rd);
      end
      do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat, ok);
      tests_run++;
      if (!ok || err !== 1'b0 || rd !== 32'hDE22BE44) begin
         tests_failed++;
         $display("FAIL partial_load: ok=%b err=%b rdata=%h want err=0 rdata=de22be44", ok, err, rd);
      end
   endtask

   task automatic test_backpressure();
      int n;
      @(negedge clk);
      req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h10; req_be[0] = 4'h0;
      n = 0;
      while (!req_ready[0] && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      // Keep a second request pending; it must not be taken while the response is held.
      req_addr[0] = 32'h14;
      n = 1;
      while (!rsp_valid[0] && n < 40) begin @(negedge clk); n++; end
      for (int c = 0; c < 5; c++) begin
         tests_run++;
         if ({rsp_valid[0], rsp_rdata[0], rsp_err[0], req_ready[0]} !== {1'b1, 32'hDE22BE44, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL backpressure_hold c%0d: got valid=%b rdata=%h err=%b ready=%b want 1 de22be44 0 0",
                     c, rsp_valid[0], rsp_rdata[0], rsp_err[0], req_ready[0]);
         end
         @(negedge clk);
      end
      req_valid[0] = 1'b0;
      rsp_ready[0] = 1'b1;
      @(negedge clk);
      rsp_ready[0] = 1'b0;
      tests_run++;
      if ({rsp_valid[0], rsp_rdata[0], rsp_err[0], req_ready[0]} !== {1'b0, 32'd0, 1'b0, 1'b1}) begin
         tests_failed++;
         $display("FAIL backpressure_release: got valid=%b rdata=%h err=%b ready=%b want 0 0 0 1",
                  rsp_valid[0], rsp_rdata[0], rsp_err[0], req_ready[0]);
      end
      $display("[TB] dut0 LD addr=00000010 held 5 cycles under backpressure");
   endtask

   task automatic test_faults();
      bit          f_we   [3] = '{1'b0, 1'b1, 1'b1};
      logic [31:0] f_addr [3] = '{32'h13, 32'h400, 32'h10};
      logic [3:0]  f_be   [3] = '{4'hF, 4'hF, 4'h0};
      logic [31:0] rd; logic err; int lat; bit ok;
      for (int f = 0; f < 3; f++) begin
         do_txn(0, f_we[f], f_addr[f], 32'h5A5A5A5A, f_be[f], rd, err, lat, ok);
         tests_run++;
         if (!ok || lat !== 2 || err !== 1'b1 || rd !== 32'd0) begin
            tests_failed++;
            $display("FAIL fault%0d addr=%h: ok=%b lat=%0d err=%b rdata=%h want lat=2 err=1 rdata=0",
                     f, f_addr[f], ok, lat, err, rd);
         end
         do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat, ok);
         tests_run++;
         if (!ok || err !== 1'b0 || rd !== 32'hDE22BE44) begin
            tests_failed++;
            $display("FAIL fault%0d_intact: ok=%b err=%b rdata=%h want err=0 rdata=de22be44", f, ok, err, rd);
         end
      end
   endtask

   task automatic test_reset_wait();
      logic [31:0] rd; logic err; int lat; bit ok; int n; bit seen;
      do_txn(1, 1'b1, 32'h20, 32'h0, 4'hF, rd, err, lat, ok);
      model_mem[1][8] = 32'h0;
      tests_run++;
      if (!ok || lat !== 4 || err !== 1'b0) begin
         tests_failed++;
         $display("FAIL ws3_prewrite: ok=%b lat=%0d err=%b want lat=4 err=0", ok, lat, err);
      end
      @(negedge clk);
      req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h20;
      req_wdata[1] = 32'hCAFEF00D; req_be[1] = 4'hF;
      n = 0;
      while (!req_ready[1] && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      req_valid[1] = 1'b0;
      @(negedge clk);
      rst[1] = 1'b1;
      @(negedge clk);
      tests_run++;
      if (req_ready[1] !== 1'b0) begin
         tests_failed++;
         $display("FAIL ready_during_reset: got %b want 0", req_ready[1]);
      end
      rst[1] = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (rsp_valid[1]) seen = 1'b1;
         @(negedge clk);
      end
      tests_run++;
      if (seen || req_ready[1] !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_abandon: valid_seen=%b ready=%b want 0 1", seen, req_ready[1]);
      end
      $display("[TB] dut1 ST addr=00000020 wdata=cafef00d abandoned by reset");
      do_txn(1, 1'b0, 32'h20, 32'h0, 4'h0, rd, err, lat, ok);
      tests_run++;
      if (!ok || lat !== 4 || err !== 1'b0 || rd !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_no_commit: ok=%b lat=%0d err=%b rdata=%h want lat=4 err=0 rdata=0", ok, lat, err, rd);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic err; int lat; bit ok; logic [31:0] wd;
      logic [31:0] exp_q [$];
      int acc_q [$];
      int sent, nrsp, last_rsp, a;
      for (int i = 0; i < 8; i++) begin
         wd = $urandom;
         do_txn(2, 1'b1, 32'h1000 + 32'(4 * i), wd, 4'hF, rd, err, lat, ok);
         model_mem[2][i] = wd;
         tests_run++;
         if (!ok || lat !== 1 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL ws0_store%0d: ok=%b lat=%0d err=%b want lat=1 err=0", i, ok, lat, err);
         end
      end
      @(negedge clk);
      rsp_ready[2] = 1'b1; req_valid[2] = 1'b1; req_we[2] = 1'b0; req_addr[2] = 32'h1000;
      sent = 0; nrsp = 0; last_rsp = -1;
      for (int c = 0; c < 60 && nrsp < 8; c++) begin
         if (rsp_valid[2]) begin
            a = (acc_q.size() > 0) ? acc_q.pop_front() : -100;
            rd = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hX;
            tests_run++;
            if (rsp_rdata[2] !== rd || rsp_err[2] !== 1'b0 || c - a !== 1 ||
                (last_rsp >= 0 && c - last_rsp !== 2)) begin
               tests_failed++;
               $display("FAIL b2b_rsp%0d: rdata=%h err=%b lat=%0d gap=%0d want rdata=%h err=0 lat=1 gap=2",
                        nrsp, rsp_rdata[2], rsp_err[2], c - a, c - last_rsp, rd);
            end
            $display("[TB] dut2 LD b2b #%0d rdata=%h err=%b", nrsp, rsp_rdata[2], rsp_err[2]);
            last_rsp = c;
            nrsp++;
         end
         if (req_ready[2] && sent < 8) begin
            exp_q.push_back(model_mem[2][sent]);
            acc_q.push_back(c);
            sent++;
         end
         @(posedge clk);
         #1;
         req_addr[2]  = 32'h1000 + 32'(4 * sent);
         req_valid[2] = (sent < 8);
         @(negedge clk);
      end
      req_valid[2] = 1'b0;
      rsp_ready[2] = 1'b0;
      tests_run++;
      if (nrsp !== 8) begin
         tests_failed++;
         $display("FAIL b2b_count: got %0d responses want 8", nrsp);
      end
   endtask

   task automatic test_random();
      logic [31:0] rd, erd, addr, wd; logic err, eerr; int lat; bit ok; int d; bit we; logic [3:0] be;
      for (int dd = 0; dd < N; dd++) begin
         for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            addr = base_of(dd) + 32'(4 * i);
            model_access(dd, 1'b1, addr, wd, 4'hF, erd, eerr);
            do_txn(dd, 1'b1, addr, wd, 4'hF, rd, err, lat, ok);
            tests_run++;
            if (!ok || err !== 1'b0) begin
               tests_failed++;
               $display("FAIL seed dut%0d addr=%h: ok=%b err=%b want err=0", dd, addr, ok, err);
            end
         end
      end
      for (int t = 0; t < 60; t++) begin
         d  = $urandom_range(0, N - 1);
         we = 1'($urandom_range(0, 1));
         be = we ? 4'($urandom_range(0, 15)) : 4'($urandom);
         wd = $urandom;
         addr = base_of(d) + 32'(4 * $urandom_range(0, 15));
         case ($urandom_range(0, 7))
            0: addr = addr + 32'($urandom_range(1, 3));
            1: addr = base_of(d) + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
            2: addr = base_of(d) - 32'd4;
            default: ;
         endcase
         model_access(d, we, addr, wd, be, erd, eerr);
         do_txn(d, we, addr, wd, be, rd, err, lat, ok);
         tests_run++;
         if (!ok || lat !== ws_of(d) + 1 || err !== eerr || rd !== erd) begin
            tests_failed++;
            $display("FAIL rand%0d dut%0d %s addr=%h be=%b: ok=%b lat=%0d err=%b rdata=%h want lat=%0d err=%b rdata=%h",
                     t, d, we ? "ST" : "LD", addr, be, ok, lat, err, rd, ws_of(d) + 1, eerr, erd);
         end
      end
   endtask

   initial begin
      rst = '1; req_valid = '0; req_we = '0; rsp_ready = '0;
      for (int d = 0; d < N; d++) begin
         req_addr[d] = 32'd0; req_wdata[d] = 32'd0; req_be[d] = 4'd0;
      end
      test_reset();
      test_store_load();
      test_partial_store();
      test_backpressure();
      test_faults();
      test_reset_wait();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
